dec_key_sequencer: RTL and testbench

Sequential round-key source for the AES-128 decryption datapath. Accepts a 128-bit cipher key and runs the forward key expansion internally, one round per cycle, to reach round key K10. It then walks back down K10, K9, … K0 one key per handshake by instantiating `inv_keyschedule`. The inverse-round pipeline consumes each key in that order.

---
 rtl/dec_key_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_dec_key_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dec_key_sequencer.sv
// AES-128 decryption round-key source: expands the cipher key forward to K10,
// then steps back K10..K0 one key per handshake through inv_keyschedule.

package dec_key_pkg;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// S-box computed as the GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map.
module sbox_element (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    import dec_key_pkg::*;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] sq;
        logic [7:0] y;
        acc = 8'h01;
        sq  = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) acc = gf_mul(acc, sq);
            sq = gf_mul(sq, sq);
        end
        y = acc ^ {acc[6:0], acc[7]} ^ {acc[5:0], acc[7:6]}
                ^ {acc[4:0], acc[7:5]} ^ {acc[3:0], acc[7:4]} ^ 8'h63;
        return y;
    endfunction

    assign dout = sbox(din);
endmodule

// One backward key-expansion step; round=1 undoes rcon 36 (K10->K9), round=10 undoes rcon 01.
module inv_keyschedule (
    input  logic [127:0] data,
    input  logic [3:0]   round,
    output logic [127:0] key_prev
);
    import dec_key_pkg::*;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] w1p, w2p, w3p, rot, sub;

    assign {w0, w1, w2, w3} = data;
    assign w3p = w3 ^ w2;
    assign w2p = w2 ^ w1;
    assign w1p = w1 ^ w0;
    assign rot = {w3p[23:0], w3p[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        sbox_element u_sbox (.din(rot[8*b +: 8]), .dout(sub[8*b +: 8]));
    end

    assign key_prev = {w0 ^ sub ^ {rcon(4'd11 - round), 24'h0}, w1p, w2p, w3p};
endmodule

module dec_key_sequencer (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic [127:0] key_out,
    output logic [3:0]   key_round,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         done
);
    import dec_key_pkg::*;

    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

    state_t       state, state_next;
    logic [127:0] key_reg, key_next;
    logic [3:0]   step, step_next;
    logic [3:0]   round_reg, round_next;
    logic         done_reg, done_next;

    logic [31:0]  w0, w1, w2, w3, rot, sub;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] inv_key;

    // Forward expansion round for the current step.
    assign {w0, w1, w2, w3} = key_reg;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_fwd_sub
        sbox_element u_sbox (.din(rot[8*b +: 8]), .dout(sub[8*b +: 8]));
    end

    assign f0 = w0 ^ sub ^ {rcon(step), 24'h0};
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    inv_keyschedule u_inv (
        .data     (key_reg),
        .round    (4'd11 - round_reg),
        .key_prev (inv_key)
    );

    // NOTE: synchronous reset clears the key register too, so key_out reads zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            key_reg   <= 128'h0;
            step      <= 4'd0;
            round_reg <= 4'd0;
            done_reg  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_next;
            key_reg   <= key_next;
            step      <= step_next;
            round_reg <= round_next;
            done_reg  <= done_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        key_next   = key_reg;
        step_next  = step;
        round_next = round_reg;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (key_load) begin
                    key_next   = key_in;
                    step_next  = 4'd1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                key_next  = {f0, f1, f2, f3};
                step_next = step + 4'd1;
                if (step == 4'd10) begin
                    state_next = EMIT;
                    round_next = 4'd10;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    if (round_reg != 4'd0) begin
                        key_next   = inv_key;
                        round_next = round_reg - 4'd1;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign key_valid = (state == EMIT);
    assign key_out   = key_reg;
    assign key_round = round_reg;
    assign done      = done_reg;
endmodule

// File: tb/tb_dec_key_sequencer.sv
// Directed bench for dec_key_sequencer using FIPS-197 A.1 and C.1 key vectors.

module tb_dec_key_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic [127:0] key_out;
    logic [3:0]   key_round;
    logic         key_valid;
    logic         key_ready;
    logic         done;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] exp_key [0:10];
    logic         known   [0:10];

    always #5 clk = ~clk;

    dec_key_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .key_load  (key_load),
        .busy      (busy),
        .key_out   (key_out),
        .key_round (key_round),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .done      (done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_expect_a1();
        exp_key[0]  = KEY_A1;
        exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) known[i] = 1'b1;
    endtask

    task automatic set_expect_c1();
        for (int i = 0; i <= 10; i++) begin
            known[i]   = 1'b0;
            exp_key[i] = 128'h0;
        end
        exp_key[0]  = KEY_C1;
        exp_key[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        exp_key[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        known[0]  = 1'b1;
        known[9]  = 1'b1;
        known[10] = 1'b1;
    endtask

    // Counts cycles until key_valid; optionally pulses key_load on cycle pulse_at.
    task automatic wait_valid(input int expected, input int pulse_at, input logic [127:0] pulse_key);
        int n = 0;
        while (!key_valid && n < 64) begin
            if (n == pulse_at) begin
                key_load = 1'b1;
                key_in   = pulse_key;
            end
            tick();
            key_load = 1'b0;
            n++;
        end
        check("k10_latency", 128'(n), 128'(expected));
    endtask

    // Drains K10..K0; ready held low for 'stall' cycles, then toggled or held high.
    task automatic consume(input int stall, input bit toggle, input int pulse_at,
                           input logic [127:0] pulse_key);
        int   exp_r = 10;
        int   cyc   = 0;
        logic r;
        while (exp_r >= 0 && cyc < 300) begin
            if (cyc < stall)  r = 1'b0;
            else if (toggle)  r = ((cyc - stall) % 2 == 0);
            else              r = 1'b1;
            key_ready = r;
            if (cyc == pulse_at) begin
                key_load = 1'b1;
                key_in   = pulse_key;
            end
            check("valid", 128'(key_valid), 128'(1));
            check("busy_emit", 128'(busy), 128'(1));
            check("round", 128'(key_round), 128'(exp_r));
            check("done_low", 128'(done), 128'(0));
            if (known[exp_r]) check("key", key_out, exp_key[exp_r]);
            tick();
            key_load = 1'b0;
            if (r) exp_r--;
            cyc++;
        end
        key_ready = 1'b0;
        check("keys_left", 128'(exp_r + 1), 128'(0));
        check("done_pulse", 128'(done), 128'(1));
        check("valid_after_k0", 128'(key_valid), 128'(0));
        check("busy_after_k0", 128'(busy), 128'(0));
    endtask

    task automatic load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        key_load  = 1'b0;
        key_ready = 1'b0;
        key_in    = 128'h0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_valid", 128'(key_valid), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_round", 128'(key_round), 128'(0));
        check("rst_key", key_out, 128'h0);

        // C.1 key, ready held high
        set_expect_c1();
        load(KEY_C1);
        wait_valid(10, -1, 128'h0);
        consume(0, 1'b0, -1, 128'h0);
        tick();
        check("done_single", 128'(done), 128'(0));
        check("valid_idle", 128'(key_valid), 128'(0));

        // A.1 key, full round-key table, ready held high
        set_expect_a1();
        load(KEY_A1);
        wait_valid(10, -1, 128'h0);
        consume(0, 1'b0, -1, 128'h0);
        tick();

        // Backpressure: five stalled cycles on K10, then ready toggles
        load(KEY_A1);
        wait_valid(10, -1, 128'h0);
        consume(5, 1'b1, -1, 128'h0);
        tick();

        // Loads while busy, in EXPAND and in EMIT, must be ignored
        set_expect_c1();
        load(KEY_C1);
        wait_valid(10, 3, KEY_A1);
        consume(0, 1'b0, 4, KEY_A1);
        tick();
        check("no_restart", 128'(busy), 128'(0));

        // Reset at the K6 step, with key_load asserted alongside it
        load(KEY_C1);
        wait_valid(10, -1, 128'h0);
        key_ready = 1'b1;
        repeat (4) tick();
        check("at_k6", 128'(key_round), 128'(6));
        key_ready = 1'b0;
        reset     = 1'b1;
        key_load  = 1'b1;
        key_in    = KEY_A1;
        tick();
        reset    = 1'b0;
        key_load = 1'b0;
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_valid", 128'(key_valid), 128'(0));
        check("mid_rst_key", key_out, 128'h0);
        check("mid_rst_round", 128'(key_round), 128'(0));
        check("mid_rst_done", 128'(done), 128'(0));
        tick();
        check("rst_beats_load", 128'(busy), 128'(0));
        set_expect_a1();
        load(KEY_A1);
        wait_valid(10, -1, 128'h0);
        consume(0, 1'b0, -1, 128'h0);

        // Back-to-back: load in the done cycle
        set_expect_c1();
        load(KEY_C1);
        check("b2b_accepted", 128'(busy), 128'(1));
        wait_valid(10, -1, 128'h0);
        consume(0, 1'b0, -1, 128'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
